// File: rtl/nibble_serial_adder.sv
// Wide adder built from one 4-bit nibble add per clock, least-significant nibble first.
// The cross-nibble carry is held in a register, so only one nibble adder sits in any path.
//
// state | meaning
// IDLE  | waiting for an operand set; in_ready high
// ADD   | one nibble per cycle, idx selects the nibble, carry is the registered chain
// DONE  | sum/cout hold the result until out_ready
module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   cin,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   cout,
   output logic                   busy
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [IW-1:0]   idx;
   logic            carry;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [4:0]      nib_sum;
   logic            last;

   assign last = (idx == LAST);

   always_comb begin
      nib_sum = {1'b0, a_q[{idx, 2'b00} +: 4]} + {1'b0, b_q[{idx, 2'b00} +: 4]} + {4'b0000, carry};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_nxt = ADD;
         end
         ADD: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand capture and the per-nibble writeback into sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx   <= '0;
         carry <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= b;
                  carry <= cin;
                  idx   <= '0;
                  sum   <= '0;
                  cout  <= 1'b0;
               end
            end
            ADD: begin
               sum[{idx, 2'b00} +: 4] <= nib_sum[3:0];
               carry                  <= nib_sum[4];
               if (last) begin
                  cout <= nib_sum[4];
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
